id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 5-stage RV32 core. It registers the decoded control bundle and operands from the decode stage into the execute stage. It also hosts load-use hazard detection, and its stall output drives the decoder's `Stall` input. It inserts bubbles on branch flush and load-use hazards, and holds on memory wait.

## Interface
Parameters:
- `XLEN`, 32, datapath width for PC, operands and immediate.
- `CNT_W`, 32, width of the bubble counter.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `id_ctrl`  in  18  decoder bundle: [17:16] CSR_ctrl, [15] CSR_inst, [14] PCtoReg_ctrl, [13] U_LUI, [12] U_AUIPC, [11] JALR, [10] JAL, [9] Btype, [8] Branch, [7:6] ALUOp, [5] ALUSrc, [4] MemtoReg, [3] MemWrite, [2] MemRead, [1] RegWrite, [0] NOP.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  XLEN each  decode-stage PC, register-file reads and immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices.
- `id_funct3`  in  3  instruction funct3.
- `id_funct7b5`  in  1  instruction bit 30.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  decoded instruction reads rs1 / rs2.
- `flush`  in  1  branch/jump taken, from the decoder's `Flush`.
- `mem_stall`  in  1  instruction or data memory not ready; freeze the pipe.
- `ex_ctrl`  out  18  registered control bundle, same layout as `id_ctrl`.
- `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`  out  XLEN  registered operands.
- `ex_rs1`, `ex_rs2`, `ex_rd`, `ex_funct3`, `ex_funct7b5`, `ex_valid`  out  registered copies of the matching inputs.
- `load_use_stall`  out  1  combinational; hold PC and IF/ID; feeds decoder `Stall`.
- `bubble_cnt`  out  CNT_W  bubbles inserted (see Configuration).

## Operation
Hazard detection is combinational:
- `hz = ex_valid & ex_ctrl[2] & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))`.
- `load_use_stall = hz & ~flush & ~mem_stall`.

Per-cycle action, highest priority first:
1. `!rst_n`: load the bubble state.
2. `mem_stall`: HOLD. All registers keep their value and no bubble is counted.
3. `flush`: BUBBLE.
4. `hz`: BUBBLE. Upstream holds the instruction via `load_use_stall`, so it re-enters next cycle.
5. Otherwise: LOAD. Capture every `id_*` input and set `ex_valid = id_valid`.
6. If `id_valid = 0` during LOAD, `ex_ctrl` takes the bubble value regardless of `id_ctrl`.

Bubble state:
- `ex_ctrl = 18'h00001` (NOP only): RegWrite, MemRead, MemWrite and Branch are all 0.
- `ex_valid = 0`, `ex_rd = ex_rs1 = ex_rs2 = 0`.
- Data fields are 0.

Boundary behaviour:
- `rd = x0` never raises a hazard.
- A load followed by a store that uses the load result only through rs2 still stalls; there is no store-data forwarding in this core.
- `flush` and `hz` in the same cycle: a single bubble, `load_use_stall = 0`, and the counter increments once.

## Timing
- Latency: 1 cycle from `id_*` to `ex_*`.
- All outputs equal the bubble state on the first edge where `rst_n = 0`, and stay there while reset is held. Reset mid-stall discards the held instruction.
- `load_use_stall` is valid in the same cycle as the hazard and lasts exactly 1 cycle per load-use pair. After the bubble, `ex_ctrl[2] = 0`, so the hazard clears.
- HOLD can last any number of cycles. `load_use_stall` is forced to 0 during HOLD and is re-evaluated in the first cycle after `mem_stall` drops.

## Configuration
- Macro `ID_EX_BUBBLE_CNT_EN`.
- Defined: `bubble_cnt` increments by 1 on every clock where a BUBBLE action is taken from (3) or (4). Reset clears it to 0. It saturates at all-ones, with no wrap. It is frozen during HOLD.
- Undefined: there is no counter register, and `bubble_cnt` is tied to 0.

## Test plan
- Reset: hold `rst_n = 0` for 2 cycles with arbitrary inputs -> `ex_ctrl = 18'h00001`, `ex_valid = 0`, `bubble_cnt = 0`.
- Load-use: `lw x5` followed by `add x6, x5, x1` -> `load_use_stall = 1` for exactly 1 cycle, then a bubble, then `add` appears in EX one cycle late. The counter (if enabled) reads 1.
- x0 / no use: `lw x0` followed by `add x6, x0, x1`, and also `lw x5` followed by `lui x5` -> no stall and no bubble.
- Flush + hazard together: `flush = 1` in the same cycle as a load-use match -> `load_use_stall = 0`, a single bubble, and the counter increments by 1.
- Memory stall: assert `mem_stall` for 3 cycles while a load is in EX and a dependent instruction is in ID -> outputs stay frozen and `load_use_stall = 0`. After release: 1 stall cycle, then normal flow.
- Saturation (macro defined, `CNT_W = 4`): issue 20 consecutive flushes -> `bubble_cnt` stops at 4'hF.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage RV32 core.
// Registers the decoded control bundle and operands into EX. It detects
// load-use hazards and raises load_use_stall. It inserts bubbles on flush
// and on load-use hazards, and holds every register while memory is busy.
// Optional feature macro: ID_EX_BUBBLE_CNT_EN (saturating bubble counter).
//
// Handshake: there is no valid/ready pair. id_valid marks a real instruction.
// mem_stall freezes the stage for as long as it is high. load_use_stall asks
// upstream to hold PC and IF/ID for one cycle while a bubble goes down the pipe.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [17:0]      id_ctrl,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [2:0]       id_funct3,
   input  logic             id_funct7b5,
   input  logic             id_valid,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             flush,
   input  logic             mem_stall,
   output logic [17:0]      ex_ctrl,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [2:0]       ex_funct3,
   output logic             ex_funct7b5,
   output logic             ex_valid,
   output logic             load_use_stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   // Bubble control word: only the NOP bit is set.
   localparam logic [17:0] BUBBLE_CTRL = 18'h00001;

   logic hz;
   logic take_bubble;

   // Load-use hazard: the load in EX writes a register that the instruction in ID reads.
   // There is no store-data forwarding, so a use through rs2 also stalls.
   always_comb begin
      hz = ex_valid & ex_ctrl[2] & (ex_rd != 5'd0) & id_valid &
           ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
      load_use_stall = hz & ~flush & ~mem_stall;
      take_bubble    = ~mem_stall & (flush | hz);
   end

   // Pipeline register priority: reset, hold on mem_stall, bubble on flush or hazard, load.
   always_ff @(posedge clk) begin
      if (!rst_n || take_bubble) begin
         ex_ctrl     <= BUBBLE_CTRL;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_funct3   <= '0;
         ex_funct7b5 <= 1'b0;
         ex_valid    <= 1'b0;
      end else if (!mem_stall) begin
         ex_ctrl     <= id_valid ? id_ctrl : BUBBLE_CTRL;
         ex_pc       <= id_pc;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_funct3   <= id_funct3;
         ex_funct7b5 <= id_funct7b5;
         ex_valid    <= id_valid;
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturating count of inserted bubbles. It is frozen during a memory hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (take_bubble && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bubble_cnt = cnt_q;
`else
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for id_ex_stage. It covers reset, load-use
// stalls, x0 and no-use cases, flush with a hazard in the same cycle, memory
// hold, id_valid=0 loads, reset in the middle of a stall and counter saturation.
// Bubble-counter expectations follow ID_EX_BUBBLE_CNT_EN (CNT_W=4 when defined).
module tb_id_ex_stage;

`ifdef ID_EX_BUBBLE_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif
  localparam int XLEN = 32;

  localparam logic [17:0] C_BUB = 18'h00001;
  localparam logic [17:0] C_LW  = 18'h00036;  // RegWrite MemRead MemtoReg ALUSrc
  localparam logic [17:0] C_ADD = 18'h00082;  // RegWrite ALUOp=10
  localparam logic [17:0] C_LUI = 18'h02022;  // U_LUI ALUSrc RegWrite
  localparam logic [17:0] C_SW  = 18'h00028;  // MemWrite ALUSrc

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [17:0]     id_ctrl;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [2:0]      id_funct3;
  logic            id_funct7b5, id_valid, id_uses_rs1, id_uses_rs2;
  logic            flush, mem_stall;
  logic [17:0]     ex_ctrl;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5, ex_valid, load_use_stall;
  logic [CW-1:0]   bubble_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_valid(id_valid), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .flush(flush), .mem_stall(mem_stall),
    .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_valid(ex_valid), .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_bub = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected counter value from the bench's own bubble tally.
  function automatic logic [63:0] exp_cnt();
`ifdef ID_EX_BUBBLE_CNT_EN
    return (exp_bub > 15) ? 64'd15 : 64'(exp_bub);
`else
    return 64'd0;
`endif
  endfunction

  task automatic chk_bubble(input string tag);
    chk({tag, "_ctrl"},  64'(ex_ctrl), 64'(C_BUB));
    chk({tag, "_valid"}, 64'(ex_valid), 64'd0);
    chk({tag, "_rd"},    64'(ex_rd), 64'd0);
    chk({tag, "_cnt"},   64'(bubble_cnt), exp_cnt());
  endtask

  // Checks an instruction that was just loaded from the (still driven) id_* inputs.
  task automatic chk_loaded(input string tag);
    exp_q.push_back({14'd0, id_ctrl, id_pc});
    exp_q.push_back({id_rs1_data, id_rs2_data});
    exp_q.push_back({id_imm, 13'd0, id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5});
    chk({tag, "_ctrl_pc"}, {14'd0, ex_ctrl, ex_pc}, exp_q.pop_front());
    chk({tag, "_data"},    {ex_rs1_data, ex_rs2_data}, exp_q.pop_front());
    chk({tag, "_fields"},  {ex_imm, 13'd0, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5},
        exp_q.pop_front());
    chk({tag, "_valid"},   64'(ex_valid), 64'd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [17:0] c, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic u1, input logic u2, input logic v);
    id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_valid = v;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_funct3 = 3'($urandom_range(0, 7)); id_funct7b5 = 1'($urandom_range(0, 1));
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; mem_stall = 1'b0;
    // Reset held for two cycles with arbitrary inputs.
    drive(18'($urandom), 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    chk_bubble("reset");
    chk("reset_pc", 64'(ex_pc), 64'd0);
    chk("reset_imm", 64'(ex_imm), 64'd0);
    rst_n = 1'b1;

    // lw x5 then add x6,x5,x1: one stall cycle, a bubble, then add lands in EX.
    drive(C_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
    chk("lw_nostall", 64'(load_use_stall), 64'd0);
    tick(); chk_loaded("lw5");
    drive(C_ADD, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1);
    chk("lu_stall", 64'(load_use_stall), 64'd1);
    tick(); exp_bub++; chk_bubble("lu_bubble");
    chk("lu_stall_clear", 64'(load_use_stall), 64'd0);
    tick(); chk_loaded("lu_add");

    // lw x0 followed by add x6,x0,x1: no hazard on x0.
    drive(C_LW, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(C_ADD, 5'd0, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1);
    chk("x0_nostall", 64'(load_use_stall), 64'd0);
    tick(); chk_loaded("x0_add");

    // lw x5 followed by lui x5: no source registers read, so no stall.
    drive(C_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
    tick();
    drive(C_LUI, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1);
    chk("lui_nostall", 64'(load_use_stall), 64'd0);
    tick(); chk_loaded("lui");

    // lw x5 then sw using x5 only as store data (rs2): still stalls.
    drive(C_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
    tick();
    drive(C_SW, 5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1);
    chk("sw_stall", 64'(load_use_stall), 64'd1);
    tick(); exp_bub++; chk_bubble("sw_bubble");
    tick(); chk_loaded("sw");

    // Flush and hazard in the same cycle: single bubble, no stall request.
    drive(C_LW, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1);
    tick();
    drive(C_ADD, 5'd7, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1);
    flush = 1'b1; #1;
    chk("flush_hz_stall", 64'(load_use_stall), 64'd0);
    tick(); exp_bub++; chk_bubble("flush_hz");
    flush = 1'b0; #1;
    chk("flush_after_stall", 64'(load_use_stall), 64'd0);
    tick(); chk_loaded("flush_next");

    // Memory hold for 3 cycles with lw x8 in EX and a dependent add in ID.
    drive(C_LW, 5'd2, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);
    tick();
    mem_stall = 1'b1;
    drive(C_ADD, 5'd1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_stall", 64'(load_use_stall), 64'd0);
      tick();
      chk("hold_ctrl", 64'(ex_ctrl), 64'(C_LW));
      chk("hold_rd", 64'(ex_rd), 64'd8);
      chk("hold_cnt", 64'(bubble_cnt), exp_cnt());
    end
    mem_stall = 1'b0; #1;
    chk("release_stall", 64'(load_use_stall), 64'd1);
    tick(); exp_bub++; chk_bubble("release_bubble");
    tick(); chk_loaded("release_add");

    // Load with id_valid=0: control becomes the bubble word, ex_valid=0.
    drive(C_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("inval_ctrl", 64'(ex_ctrl), 64'(C_BUB));
    chk("inval_valid", 64'(ex_valid), 64'd0);
    chk("inval_cnt", 64'(bubble_cnt), exp_cnt());

    // Reset in the middle of a stall discards the held instruction.
    drive(C_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
    tick();
    drive(C_ADD, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1);
    chk("prerst_stall", 64'(load_use_stall), 64'd1);
    rst_n = 1'b0;
    tick(); exp_bub = 0; chk_bubble("midrst");
    chk("midrst_stall", 64'(load_use_stall), 64'd0);
    rst_n = 1'b1;

    // 20 consecutive flushes: the counter saturates when enabled.
    flush = 1'b1;
    drive(C_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(); exp_bub++;
    end
    chk_bubble("sat");
    flush = 1'b0;
    tick(); chk_loaded("post_sat");
    chk("post_sat_cnt", 64'(bubble_cnt), exp_cnt());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
